// File: rtl/riscv_alu_pkg.sv
// Shared constants and types for the RV32IM ALU issue decode stage.
// ALU op codes, opcode/funct7 values and the decoded payload bundle.
package riscv_alu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_MUL    = 5'd2;
    localparam logic [4:0] ALU_MULH   = 5'd3;
    localparam logic [4:0] ALU_MULHSU = 5'd4;
    localparam logic [4:0] ALU_MULHU  = 5'd5;
    localparam logic [4:0] ALU_DIV    = 5'd6;
    localparam logic [4:0] ALU_DIVU   = 5'd7;
    localparam logic [4:0] ALU_REM    = 5'd8;
    localparam logic [4:0] ALU_REMU   = 5'd9;
    localparam logic [4:0] ALU_XOR    = 5'd10;
    localparam logic [4:0] ALU_OR     = 5'd11;
    localparam logic [4:0] ALU_AND    = 5'd12;
    localparam logic [4:0] ALU_SLL    = 5'd13;
    localparam logic [4:0] ALU_SRL    = 5'd14;
    localparam logic [4:0] ALU_SRA    = 5'd15;
    localparam logic [4:0] ALU_SLT    = 5'd16;
    localparam logic [4:0] ALU_SLTU   = 5'd17;
    localparam logic [4:0] ALU_SEQ    = 5'd18;
    localparam logic [4:0] ALU_SNE    = 5'd19;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [31:0] ina;
        logic [31:0] inb;
        logic [4:0]  rd;
        logic        inv;
        logic        illegal;
    } alu_dec_t;

    // funct3 -> op for the funct7=0 register and immediate forms
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_alu_decode_if.sv
// Valid/ready bundle between register read, the decode stage and the ALU.
// slave is the decode stage's view; master is the driving/consuming side.
interface riscv_alu_decode_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  ALU_ctrl;
    logic [31:0] ALU_ina;
    logic [31:0] ALU_inb;
    logic [4:0]  out_rd;
    logic        out_br_invert;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, ALU_ctrl, ALU_ina, ALU_inb,
        output out_rd, out_br_invert, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, ALU_ctrl, ALU_ina, ALU_inb,
        input  out_rd, out_br_invert, out_illegal
    );

endinterface

// File: rtl/riscv_alu_decode_comb.sv
// Pure combinational instruction -> ALU control/operand decode.
// Illegal encodings collapse to an all-zero payload with illegal set.
module riscv_alu_decode_comb
    import riscv_alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output alu_dec_t    dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        ok;
    alu_dec_t    d;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u = {instr[31:12], 12'b0};
    assign shamt = {27'b0, instr[24:20]};

    always_comb begin
        d       = '0;
        ok      = 1'b1;
        d.rd    = instr[11:7];
        d.ina   = rs1;
        d.inb   = imm_i;
        d.ctrl  = ALU_ADD;
        case (opc)
            OPC_OP: begin
                d.inb = rs2;
                case (f7)
                    F7_BASE:   d.ctrl = base_op(f3);
                    F7_MULDIV: d.ctrl = ALU_MUL + {2'b0, f3};
                    F7_ALT: begin
                        if (f3 == 3'b000)      d.ctrl = ALU_SUB;
                        else if (f3 == 3'b101) d.ctrl = ALU_SRA;
                        else                   ok = 1'b0;
                    end
                    default: ok = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                d.ctrl = base_op(f3);
                if (f3 == 3'b001) begin
                    d.inb = shamt;
                    ok    = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    d.inb = shamt;
                    if (f7 == F7_ALT)       d.ctrl = ALU_SRA;
                    else if (f7 != F7_BASE) ok = 1'b0;
                end
            end
            OPC_LUI: begin
                d.ina = '0;
                d.inb = imm_u;
            end
            OPC_AUIPC: begin
                d.ina = pc;
                d.inb = imm_u;
            end
            OPC_LOAD, OPC_JALR: ;
            OPC_STORE: begin
                d.inb = imm_s;
                d.rd  = '0;
            end
            OPC_BRANCH: begin
                d.inb = rs2;
                d.rd  = '0;
                // BGE/BGEU reuse the less-than compare and flip the result
                case (f3)
                    3'b000: d.ctrl = ALU_SEQ;
                    3'b001: d.ctrl = ALU_SNE;
                    3'b100: d.ctrl = ALU_SLT;
                    3'b101: begin d.ctrl = ALU_SLT;  d.inv = 1'b1; end
                    3'b110: d.ctrl = ALU_SLTU;
                    3'b111: begin d.ctrl = ALU_SLTU; d.inv = 1'b1; end
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d         = '0;
            d.illegal = 1'b1;
        end
    end

    assign dec = d;

endmodule

// File: rtl/riscv_alu_decode.sv
// Issue-side ALU decode stage: combinational decode into a registered
// output slot backed by an optional skid entry for full-rate backpressure.
module riscv_alu_decode
    import riscv_alu_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    riscv_alu_decode_if.slave  bus
);

    alu_dec_t dec;
    alu_dec_t out_q, out_d;
    alu_dec_t skid_q, skid_d;
    logic     out_valid_q, out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     in_ready;
    logic     acc;

    riscv_alu_decode_comb u_comb (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .rs1   (bus.in_rs1),
        .rs2   (bus.in_rs2),
        .dec   (dec)
    );

    assign in_ready = SKID_EN ? !skid_valid_q
                              : (!out_valid_q || bus.out_ready);
    assign acc      = bus.in_valid && in_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (SKID_EN && skid_valid_q) begin
            // skid full: in_ready is low, only drain into the output slot
            if (bus.out_ready) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (acc) begin
            if (!out_valid_q || bus.out_ready) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else if (SKID_EN) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.ALU_ctrl      = out_q.ctrl;
    assign bus.ALU_ina       = out_q.ina;
    assign bus.ALU_inb       = out_q.inb;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_br_invert = out_q.inv;
    assign bus.out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_riscv_alu_decode.sv
// Directed bench for riscv_alu_decode: decode vectors, skid backpressure,
// illegal encodings and asynchronous reset with both entries full.
module tb_riscv_alu_decode;

    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    riscv_alu_decode_if bus ();

    riscv_alu_decode #(.SKID_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
    endtask

    task automatic test_reset();
        n_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.ALU_ctrl !== 5'd0 || bus.ALU_ina !== 32'd0 ||
            bus.ALU_inb !== 32'd0 || bus.out_rd !== 5'd0 ||
            bus.out_illegal !== 1'b0 || bus.out_br_invert !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: v=%b rdy=%b ctrl=%0d a=%h b=%h rd=%0d ill=%b inv=%b want 0 1 0 0 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.ALU_ctrl, bus.ALU_ina,
                     bus.ALU_inb, bus.out_rd, bus.out_illegal, bus.out_br_invert);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  ctrl;
        logic [31:0] ina;
        logic [31:0] inb;
        logic [4:0]  rd;
        logic        inv;
        logic        ill;
    } vec_t;

    task automatic run_vecs(input vec_t v[$]);
        bus.out_ready = 1'b1;
        foreach (v[i]) begin
            drive(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
            tick();
            bus.in_valid = 1'b0;
            n_run++;
            if (bus.out_valid !== 1'b1 || bus.ALU_ctrl !== v[i].ctrl ||
                bus.ALU_ina !== v[i].ina || bus.ALU_inb !== v[i].inb ||
                bus.out_rd !== v[i].rd || bus.out_br_invert !== v[i].inv ||
                bus.out_illegal !== v[i].ill) begin
                n_fail++;
                $display("FAIL %s: v=%b ctrl=%0d a=%h b=%h rd=%0d inv=%b ill=%b want v=1 ctrl=%0d a=%h b=%h rd=%0d inv=%b ill=%b",
                         v[i].name, bus.out_valid, bus.ALU_ctrl, bus.ALU_ina,
                         bus.ALU_inb, bus.out_rd, bus.out_br_invert,
                         bus.out_illegal, v[i].ctrl, v[i].ina, v[i].inb,
                         v[i].rd, v[i].inv, v[i].ill);
            end
        end
        tick();
    endtask

    task automatic test_decode();
        vec_t v[$];
        v.push_back('{"add",    32'h002081B3, 32'h100, 32'd5,        32'd7, 5'd0,  32'd5,        32'd7,        5'd3, 1'b0, 1'b0});
        v.push_back('{"srai",   32'h40315093, 32'h104, 32'h80000000, 32'd9, 5'd15, 32'h80000000, 32'd3,        5'd1, 1'b0, 1'b0});
        v.push_back('{"bge",    32'h0020D063, 32'h108, 32'd11,       32'd4, 5'd16, 32'd11,       32'd4,        5'd0, 1'b1, 1'b0});
        v.push_back('{"lui",    32'h123452B7, 32'h10C, 32'd77,       32'd1, 5'd0,  32'd0,        32'h12345000, 5'd5, 1'b0, 1'b0});
        v.push_back('{"sub",    32'h40208033, 32'h110, 32'd9,        32'd2, 5'd1,  32'd9,        32'd2,        5'd0, 1'b0, 1'b0});
        v.push_back('{"mul",    32'h022081B3, 32'h114, 32'd3,        32'd6, 5'd2,  32'd3,        32'd6,        5'd3, 1'b0, 1'b0});
        v.push_back('{"rem",    32'h0220E1B3, 32'h118, 32'd8,        32'd5, 5'd8,  32'd8,        32'd5,        5'd3, 1'b0, 1'b0});
        v.push_back('{"sltiu",  32'hFFF13093, 32'h11C, 32'd4,        32'd0, 5'd17, 32'd4,        32'hFFFFFFFF, 5'd1, 1'b0, 1'b0});
        v.push_back('{"auipc",  32'h00001097, 32'h120, 32'd1,        32'd2, 5'd0,  32'h120,      32'h00001000, 5'd1, 1'b0, 1'b0});
        v.push_back('{"sw",     32'h0020A423, 32'h124, 32'h40,       32'd2, 5'd0,  32'h40,       32'd8,        5'd0, 1'b0, 1'b0});
        v.push_back('{"lw",     32'hFFC12083, 32'h128, 32'h50,       32'd3, 5'd0,  32'h50,       32'hFFFFFFFC, 5'd1, 1'b0, 1'b0});
        v.push_back('{"bgeu",   32'h0020F063, 32'h12C, 32'd1,        32'd2, 5'd17, 32'd1,        32'd2,        5'd0, 1'b1, 1'b0});
        v.push_back('{"bne",    32'h00209063, 32'h130, 32'd1,        32'd2, 5'd19, 32'd1,        32'd2,        5'd0, 1'b0, 1'b0});
        v.push_back('{"slli",   32'h00511093, 32'h134, 32'd1,        32'd2, 5'd13, 32'd1,        32'd5,        5'd1, 1'b0, 1'b0});
        run_vecs(v);
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back('{"ill_ones", 32'hFFFFFFFF, 32'h200, 32'd5, 32'd6, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
        v.push_back('{"ill_f7",   32'h04208033, 32'h204, 32'd5, 32'd6, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
        v.push_back('{"ill_br",   32'h0020A063, 32'h208, 32'd5, 32'd6, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
        v.push_back('{"ill_slli", 32'h40511093, 32'h20C, 32'd5, 32'd6, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
        v.push_back('{"ill_alt",  32'h4020C033, 32'h210, 32'd5, 32'd6, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1});
        run_vecs(v);
    endtask

    task automatic chk_out(input string name, input logic v,
                           input logic rdy, input logic [31:0] a,
                           input logic [31:0] b);
        n_run++;
        if (bus.out_valid !== v || bus.in_ready !== rdy ||
            (v && (bus.ALU_ina !== a || bus.ALU_inb !== b))) begin
            n_fail++;
            $display("FAIL %s: v=%b rdy=%b a=%h b=%h want v=%b rdy=%b a=%h b=%h",
                     name, bus.out_valid, bus.in_ready, bus.ALU_ina,
                     bus.ALU_inb, v, rdy, a, b);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'hA1, 32'hB1);
        tick();
        chk_out("b2b_1", 1'b1, 1'b1, 32'hA1, 32'hB1);
        drive(32'h002081B3, 32'h0, 32'hA2, 32'hB2);
        tick();
        chk_out("b2b_2", 1'b1, 1'b0, 32'hA1, 32'hB1);
        drive(32'h002081B3, 32'h0, 32'hA3, 32'hB3);
        tick();
        chk_out("b2b_hold", 1'b1, 1'b0, 32'hA1, 32'hB1);
        bus.out_ready = 1'b1;
        tick();
        chk_out("b2b_out2", 1'b1, 1'b1, 32'hA2, 32'hB2);
        tick();
        bus.in_valid = 1'b0;
        chk_out("b2b_out3", 1'b1, 1'b1, 32'hA3, 32'hB3);
        tick();
        chk_out("b2b_drain", 1'b0, 1'b1, 32'h0, 32'h0);
        tick();
        chk_out("b2b_nodup", 1'b0, 1'b1, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'hC1, 32'hD1);
        tick();
        drive(32'h002081B3, 32'h0, 32'hC2, 32'hD2);
        tick();
        bus.in_valid = 1'b0;
        chk_out("rst_full", 1'b1, 1'b0, 32'hC1, 32'hD1);
        #2 reset = 1'b1;
        #1;
        n_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.ALU_ina !== 32'd0 || bus.ALU_inb !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async: v=%b rdy=%b a=%h b=%h want 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.ALU_ina, bus.ALU_inb);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("rst_nostale", 1'b0, 1'b1, 32'h0, 32'h0);
        end
    endtask

    initial begin
        n_run         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        test_reset();
        test_decode();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_alu_decode.md
# riscv_alu_decode

Issue-side decode stage that feeds the RV32IM ALU. Accepts one instruction word plus PC and register-file operands per valid/ready handshake, decodes it into the 5-bit ALU operation code and the two 32-bit ALU operands, and presents them through a registered, two-entry skid-buffered output. It sits between register read and the ALU in the execute pipeline and fully absorbs downstream backpressure.

## Interface
- SKID_EN, 1: 1 = two-entry skid buffer; 0 = single output register, with in_ready = !out_valid || out_ready.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- in_rs1  in  32  rs1 register value
- in_rs2  in  32  rs2 register value
- out_valid  out  1  decoded beat valid
- out_ready  in  1  ALU side accepts beat
- ALU_ctrl  out  5  ALU operation code
- ALU_ina  out  32  operand A
- ALU_inb  out  32  operand B
- out_rd  out  5  destination register, instr[11:7]; 0 for BRANCH/STORE
- out_br_invert  out  1  consumer inverts the ALU result bit (BGE/BGEU)
- out_illegal  out  1  instruction not decodable

## Operation
- ALU_ctrl codes: ADD 0, SUB 1, MUL 2, MULH 3, MULHSU 4, MULHU 5, DIV 6, DIVU 7, REM 8, REMU 9, XOR 10, OR 11, AND 12, SLL 13, SRL 14, SRA 15, SLT 16, SLTU 17, SEQ 18, SNE 19.
- OP (0110011): ina=rs1, inb=rs2. Funct7 0000000 selects the base op by funct3 (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND). Funct7 0100000 is legal only for funct3 000 (SUB) and 101 (SRA). Funct7 0000001 selects codes 2..9 by funct3 in order MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Any other funct7 is illegal.
- OP-IMM (0010011): ina=rs1, inb=sign-extended imm[31:20]. Shifts use inb={27'b0, shamt}. SLLI requires funct7 0000000. SRLI/SRAI require funct7 0000000/0100000. SLTIU compares against the sign-extended immediate as unsigned.
- LUI: ADD, ina=0, inb={instr[31:12], 12'b0}.
- AUIPC: ADD, ina=pc, inb=U-immediate.
- LOAD, JALR: ADD, ina=rs1, inb=I-immediate.
- STORE: ADD, ina=rs1, inb=S-immediate.
- BRANCH: ina=rs1, inb=rs2. Mapping is BEQ→SEQ, BNE→SNE, BLT→SLT, BGE→SLT with invert, BLTU→SLTU, BGEU→SLTU with invert. Funct3 010/011 is illegal.
- Illegal (any other opcode or bad field): ALU_ctrl=0, ina=inb=0, rd=0, out_illegal=1. The beat still passes through the handshake normally.
- Decode is combinational on the input. Results are captured into the output register on acceptance.

## Timing
- A beat is accepted when in_valid && in_ready. It is transferred out when out_valid && out_ready.
- Latency is 1 cycle: a beat accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 beat/cycle while out_ready=1.
- With SKID_EN=1, in_ready is registered and equals !skid_valid.
  - When the output register is full and out_ready=0, an accepted beat goes to the skid entry and in_ready falls on the next cycle.
  - When out_ready=1 with skid full, the skid entry moves to the output register, and in_ready returns the following cycle.
- Simultaneous accept and transfer with the skid empty: the output register loads the new beat and out_valid stays 1.
- Order is strictly preserved. Beats are never dropped or duplicated.
- Output payload is held stable while out_valid && !out_ready.
- Reset values (asserted asynchronously, mid-operation included): out_valid=0, skid entry invalid, in_ready=1, all payload outputs 0. Both entries are discarded.

## Structure
- Package riscv_alu_pkg holds:
  - the 20 ALU_ctrl code localparams;
  - the opcode constants (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JALR);
  - the funct7 constants.
- Sub-module riscv_alu_decode_comb contains the pure combinational instruction→{ctrl, ina, inb, rd, invert, illegal} decode. The top level holds the output register and the skid buffer.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle ALU_ctrl=0, ina=5, inb=7, out_rd=3, out_illegal=0.
- srai x1,x2,3 (0x40315093), rs1=0x80000000 → ALU_ctrl=15, ina=0x80000000, inb=3.
- bge x1,x2 (0x0020D063) → ALU_ctrl=16, out_br_invert=1, out_rd=0. lui x5,0x12345 (0x123452B7) → ALU_ctrl=0, ina=0, inb=0x12345000, out_rd=5.
- Three back-to-back beats with out_ready=0 for 3 cycles:
  - beats 1–2 are accepted and in_ready=0 after the 2nd;
  - the 3rd is held until out_ready=1;
  - all three then emerge in order with stable payload.
- in_instr=0xFFFFFFFF → out_illegal=1, ALU_ctrl=0, ina=inb=0. Asserting reset while out_valid=1 and skid full → out_valid=0 and in_ready=1 immediately, with no stale beat after release.
